// File: rtl/axis_txfifo_playback_ctrl_if.sv
// rtl/axis_txfifo_playback_ctrl_if.sv - load and playback stream handshake bundle
interface axis_txfifo_playback_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tlast;
    logic                  s_axis_tready;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/axis_txfifo_playback_ctrl.sv
// rtl/axis_txfifo_playback_ctrl.sv - three-bank waveform buffer load/playback sequencer
module axis_txfifo_playback_ctrl #(
    parameter int BANK_ADDR_WIDTH = 11,
    parameter int ADDR_WIDTH      = 13,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_clear,
    input  logic                        cfg_start,
    input  logic                        cfg_stop,
    input  logic                        cfg_loop,
    input  logic [BANK_ADDR_WIDTH:0]    cfg_length,
    axis_txfifo_playback_ctrl_if.slave  axis,
    output logic                        mem_we,
    output logic [ADDR_WIDTH-1:0]       mem_waddr,
    output logic [DATA_WIDTH:0]         mem_wdata,
    output logic                        mem_re,
    output logic [BANK_ADDR_WIDTH-1:0]  mem_raddr,
    output logic                        out_load,
    output logic [2:0]                  state,
    output logic                        load_done,
    output logic                        cfg_err,
    output logic [15:0]                 wrap_count
);
    localparam int BAW = BANK_ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ARMED = 3'd2,
        S_PLAY  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [BAW:0]    len_q;
    logic [BAW:0]    len_m1_full;
    logic [BAW-1:0]  len_m1;
    logic [1:0]      wr_bank_q;
    logic [BAW-1:0]  wr_idx_q;
    logic [BAW-1:0]  rd_idx_q;
    logic            s1_valid_q, s1_last_q;
    logic            tvalid_q, tlast_q;
    logic            load_done_q, cfg_err_q;
    logic [15:0]     wrap_count_q;

    logic cfg_ok_state, clear_ok, clear_bad, hs, wr_last, rd_re, rd_wrap, ld, drain_done, start_ok;

    assign len_m1_full  = len_q - 1'b1;
    assign len_m1       = len_m1_full[BAW-1:0];
    assign cfg_ok_state = (state_q == S_IDLE) || (state_q == S_ARMED);
    assign clear_ok     = cfg_ok_state && cfg_clear && (cfg_length != '0);
    assign clear_bad    = cfg_ok_state && cfg_clear && (cfg_length == '0);
    assign hs           = (state_q == S_LOAD) && axis.s_axis_tvalid;
    assign wr_last      = hs && (wr_bank_q == 2'd2) && (wr_idx_q == len_m1);
    assign ld           = s1_valid_q && (!tvalid_q || axis.m_axis_tready);
    assign rd_re        = (state_q == S_PLAY) && !cfg_stop && (!s1_valid_q || ld);
    assign rd_wrap      = rd_re && (rd_idx_q == len_m1);
    assign drain_done   = !s1_valid_q && (!tvalid_q || axis.m_axis_tready);
    assign start_ok     = (state_q == S_ARMED) && cfg_start && !cfg_stop && !cfg_clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (clear_ok) state_d = S_LOAD;
            S_LOAD: begin
                if (cfg_stop)                             state_d = S_IDLE;
                else if (wr_last)                         state_d = S_ARMED;
                else if (hs && axis.s_axis_tlast)         state_d = S_IDLE;
            end
            S_ARMED: begin
                if (clear_ok)       state_d = S_LOAD;
                else if (clear_bad) state_d = S_IDLE;
                else if (start_ok)  state_d = S_PLAY;
            end
            S_PLAY:  if (cfg_stop || (rd_wrap && !cfg_loop)) state_d = S_DRAIN;
            S_DRAIN: if (drain_done) state_d = S_ARMED;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        axis.s_axis_tready = (state_q == S_LOAD);
        axis.m_axis_tvalid = tvalid_q;
        axis.m_axis_tlast  = tvalid_q && tlast_q;
        mem_we     = hs;
        mem_waddr  = {wr_bank_q, wr_idx_q};
        mem_wdata  = hs ? {axis.s_axis_tlast, axis.s_axis_tdata} : '0;
        mem_re     = rd_re;
        mem_raddr  = rd_idx_q;
        out_load   = ld;
        state      = state_q;
        load_done  = load_done_q;
        cfg_err    = cfg_err_q;
        wrap_count = wrap_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q        <= '0;
            wr_bank_q    <= '0;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            load_done_q  <= 1'b0;
            cfg_err_q    <= 1'b0;
            wrap_count_q <= '0;
        end else begin
            if (clear_ok) begin
                // Lengths beyond one bank clamp to a full bank.
                len_q       <= cfg_length[BAW] ? {1'b1, {BAW{1'b0}}} : cfg_length;
                wr_bank_q   <= '0;
                wr_idx_q    <= '0;
                load_done_q <= 1'b0;
                cfg_err_q   <= 1'b0;
            end else if (clear_bad) begin
                cfg_err_q <= 1'b1;
            end

            if (state_q == S_LOAD && cfg_stop) begin
                load_done_q <= 1'b0;
            end else if (hs) begin
                if (wr_idx_q == len_m1) begin
                    wr_idx_q  <= '0;
                    wr_bank_q <= wr_bank_q + 2'd1;
                end else begin
                    wr_idx_q <= wr_idx_q + 1'b1;
                end
                if (wr_last) begin
                    load_done_q <= 1'b1;
                    if (!axis.s_axis_tlast) cfg_err_q <= 1'b1;
                end else if (axis.s_axis_tlast) begin
                    cfg_err_q <= 1'b1;
                end
            end

            if (start_ok) begin
                rd_idx_q     <= '0;
                wrap_count_q <= '0;
            end else if (rd_re) begin
                rd_idx_q <= rd_wrap ? '0 : rd_idx_q + 1'b1;
                if (rd_wrap && cfg_loop && wrap_count_q != 16'hFFFF)
                    wrap_count_q <= wrap_count_q + 16'd1;
            end

            // The tlast tag rides alongside each read through both stages.
            s1_valid_q <= rd_re || (s1_valid_q && !ld);
            if (rd_re) s1_last_q <= (rd_idx_q == len_m1);
            tvalid_q <= ld || (tvalid_q && !axis.m_axis_tready);
            if (ld) tlast_q <= s1_last_q;
        end
    end
endmodule

// File: tb/tb_axis_txfifo_playback_ctrl.sv
// tb/tb_axis_txfifo_playback_ctrl.sv - directed self-checking bench for the playback sequencer
module tb_axis_txfifo_playback_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_clear, cfg_start, cfg_stop, cfg_loop;
    logic [11:0] cfg_length;
    logic        mem_we, mem_re, out_load, load_done, cfg_err;
    logic [12:0] mem_waddr;
    logic [32:0] mem_wdata;
    logic [10:0] mem_raddr;
    logic [2:0]  state;
    logic [15:0] wrap_count;

    int n_chk  = 0;
    int n_pass = 0;

    axis_txfifo_playback_ctrl_if #(.DATA_WIDTH(32)) bus ();

    axis_txfifo_playback_ctrl dut (
        .clk(clk), .rst(rst),
        .cfg_clear(cfg_clear), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_loop(cfg_loop), .cfg_length(cfg_length),
        .axis(bus.slave),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .out_load(out_load),
        .state(state), .load_done(load_done), .cfg_err(cfg_err),
        .wrap_count(wrap_count)
    );

    always #5 clk = ~clk;

    // Model of the RAM read register and output register driven by mem_re/out_load.
    logic [10:0] s1_data, out_data;
    logic [11:0] beats[$];
    logic [10:0] reads[$];
    int          drops = 0;
    logic        prev_v, prev_r;

    always @(negedge clk) begin
        if (rst) begin
            s1_data = '0; out_data = '0; prev_v = 1'b0; prev_r = 1'b0;
        end else begin
            if (bus.m_axis_tvalid && bus.m_axis_tready) beats.push_back({bus.m_axis_tlast, out_data});
            if (prev_v && !prev_r && !bus.m_axis_tvalid) drops++;
            prev_v = bus.m_axis_tvalid;
            prev_r = bus.m_axis_tready;
            if (out_load) out_data = s1_data;
            if (mem_re) begin
                s1_data = mem_raddr;
                reads.push_back(mem_raddr);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int lc, input int n, input int tl);
        int ln;
        ln = (lc > 2048) ? 2048 : lc;
        cfg_length = 12'(lc);
        cfg_clear  = 1'b1;
        cyc();
        cfg_clear = 1'b0;
        check("load_entry_err", cfg_err, 0);
        check("load_tready", bus.s_axis_tready, 1);
        for (int i = 0; i < n; i++) begin
            bus.s_axis_tdata  = 32'hD000 + i;
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tlast  = (i == tl);
            #1;
            check("we", mem_we, 1);
            check("waddr", mem_waddr, (i / ln) * 2048 + (i % ln));
            check("wdata", mem_wdata, {(i == tl), 32'hD000 + i});
            cyc();
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        cyc();
        cfg_start = 1'b0;
    endtask

    initial begin
        int r0, b0, d0, nb;
        bit done;
        rst = 1'b1;
        cfg_clear = 0; cfg_start = 0; cfg_stop = 0; cfg_loop = 0; cfg_length = '0;
        bus.s_axis_tdata = '0; bus.s_axis_tvalid = 0; bus.s_axis_tlast = 0; bus.m_axis_tready = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", state, 0);
        check("rst_tready", bus.s_axis_tready, 0);
        check("rst_we", mem_we, 0);
        check("rst_re", mem_re, 0);
        check("rst_tvalid", bus.m_axis_tvalid, 0);
        check("rst_load_done", load_done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_wrap", wrap_count, 0);
        rst = 1'b0;
        cyc();

        // Load len=4, 12 words
        load(4, 12, 11);
        check("ld1_done", load_done, 1);
        check("ld1_state", state, 2);
        check("ld1_err", cfg_err, 0);

        // Start and stop together: stop wins
        bus.m_axis_tready = 1'b1;
        cfg_start = 1'b1; cfg_stop = 1'b1;
        cyc();
        cfg_start = 1'b0; cfg_stop = 1'b0;
        check("startstop_state", state, 2);

        // One-shot len=4 with tready=1
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            #1;
            check("os_re", mem_re, (k < 4));
            if (k < 4) check("os_raddr", mem_raddr, k);
            check("os_tvalid", bus.m_axis_tvalid, (k >= 2 && k <= 5));
            check("os_tlast", bus.m_axis_tlast, (k == 5));
            cyc();
        end
        check("os_armed", state, 2);
        check("os_done", load_done, 1);

        // Loop len=3, 10 reads then stop
        load(3, 9, 8);
        check("ld3_state", state, 2);
        cfg_loop = 1'b1;
        r0 = reads.size(); b0 = beats.size();
        pulse_start();
        repeat (10) cyc();
        check("loop_wrap", wrap_count, 3);
        check("loop_reads", reads.size() - r0, 10);
        for (int i = 0; i < 10; i++) check("loop_raddr", reads[r0 + i], i % 3);
        cfg_stop = 1'b1;
        #1;
        check("stop_no_re", mem_re, 0);
        nb = beats.size();
        cyc();
        cfg_stop = 1'b0;
        done = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            if (state == 3'd2) done = 1;
            else cyc();
        end
        check("stop_armed", state, 2);
        check("stop_beats", beats.size() - nb, 2);
        check("loop_beats", beats.size() - b0, 10);
        for (int i = 0; i < 10 && (b0 + i) < beats.size(); i++)
            check("loop_beat", beats[b0 + i], {(i % 3 == 2), 11'(i % 3)});
        cfg_loop = 1'b0;

        // len=8 with tready pattern 1,0,0
        load(8, 24, 23);
        r0 = reads.size(); b0 = beats.size(); d0 = drops;
        pulse_start();
        done = 0;
        for (int c = 0; c < 80 && !done; c++) begin
            bus.m_axis_tready = (c % 3 == 0);
            cyc();
            if (state == 3'd2) done = 1;
        end
        bus.m_axis_tready = 1'b1;
        check("bp_armed", state, 2);
        check("bp_reads", reads.size() - r0, 8);
        check("bp_beats", beats.size() - b0, 8);
        for (int i = 0; i < 8 && (b0 + i) < beats.size(); i++)
            check("bp_beat", beats[b0 + i], {(i == 7), 11'(i)});
        check("bp_drops", drops - d0, 0);

        // Zero length clear from ARMED
        cfg_length = '0;
        cfg_clear  = 1'b1;
        cyc();
        cfg_clear = 1'b0;
        check("len0_err", cfg_err, 1);
        check("len0_state", state, 0);
        cyc();
        check("len0_stay", state, 0);

        // Early tlast aborts the load
        load(4, 6, 5);
        check("early_err", cfg_err, 1);
        check("early_state", state, 0);
        check("early_done", load_done, 0);

        // Reset in the middle of playback
        load(4, 12, 11);
        bus.m_axis_tready = 1'b0;
        pulse_start();
        repeat (3) cyc();
        check("mid_tvalid", bus.m_axis_tvalid, 1);
        rst = 1'b1;
        #1;
        check("arst_state", state, 0);
        check("arst_tvalid", bus.m_axis_tvalid, 0);
        check("arst_tlast", bus.m_axis_tlast, 0);
        check("arst_re", mem_re, 0);
        check("arst_out_load", out_load, 0);
        check("arst_done", load_done, 0);
        check("arst_raddr", mem_raddr, 0);
        check("arst_waddr", mem_waddr, 0);
        #2;
        rst = 1'b0;
        cyc();
        check("post_rst_state", state, 0);
        check("post_rst_tvalid", bus.m_axis_tvalid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
